// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one load/store at a time and
// returns a single-cycle valid pulse a fixed LATENCY cycles after the request.
module dmem_responder #(
    parameter logic [31:0] BASE    = 32'h10010000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  width,
    input  logic        ext,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    logic [3:0]    cnt;
    logic          accept;
    logic [31:0]   word_off;
    logic [AW-1:0] mem_idx;
    logic          in_range;
    logic          illegal;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    logic          we_q;
    logic [1:0]    width_q;
    logic [1:0]    lane_q;
    logic          ext_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;

    assign accept   = req && (state == IDLE);
    assign word_off = (addr - BASE) >> 2;
    assign mem_idx  = word_off[AW-1:0];
    assign in_range = (addr >= BASE) && (word_off < 32'(DEPTH));

    assign illegal = (width == 2'b11)
                  || ((width == 2'b01) && addr[0])
                  || ((width == 2'b10) && (addr[1:0] != 2'b00))
                  || !in_range;

    // Right-aligned store data is replicated across lanes; be picks the live ones.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata;
        case (width)
            2'b00: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            2'b10: begin
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: begin
                be     = 4'b0000;
                wlanes = wdata;
            end
        endcase
    end

    // Memory has no reset so stores survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (accept && !illegal) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[mem_idx][8*i +: 8] <= wlanes[8*i +: 8];
                    end
                end
            end else begin
                rd_word <= mem[mem_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            width_q <= 2'b00;
            lane_q  <= 2'b00;
            ext_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= CNT_INIT;
                        we_q    <= we;
                        width_q <= width;
                        lane_q  <= addr[1:0];
                        ext_q   <= ext;
                        err_q   <= illegal;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_byte = rd_word[8*lane_q +: 8];
    assign sel_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    // Response fields are forced to zero outside the valid pulse.
    always_comb begin
        ready = (state == IDLE);
        valid = (state == RESP);
        rdata = 32'h0;
        err   = 1'b0;
        if (valid) begin
            err = err_q;
            if (!err_q && !we_q) begin
                case (width_q)
                    2'b00:   rdata = {{24{~ext_q & sel_byte[7]}}, sel_byte};
                    2'b01:   rdata = {{16{~ext_q & sel_half[15]}}, sel_half};
                    2'b10:   rdata = rd_word;
                    default: rdata = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table-driven loads/stores through a scoreboard,
// plus hand-written reset-abort and back-to-back latency sequences.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h10010000;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req3 = 1'b0;
    logic        req1 = 1'b0;
    logic        we = 1'b0;
    logic        ext = 1'b0;
    logic [1:0]  width = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        ready, valid, err;
    logic [31:0] rdata;
    logic        ready3, valid3, err3;
    logic [31:0] rdata3;
    logic        ready1, valid1, err1;
    logic [31:0] rdata1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    typedef struct {
        logic        e;
        logic [31:0] d;
        int          at;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_x;

    dmem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .width(width),
        .ext(ext), .wdata(wdata), .ready(ready), .valid(valid), .rdata(rdata), .err(err)
    );

    dmem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .width(width),
        .ext(ext), .wdata(wdata), .ready(ready3), .valid(valid3), .rdata(rdata3), .err(err3)
    );

    dmem_responder #(.BASE(BASE), .DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .width(width),
        .ext(ext), .wdata(wdata), .ready(ready1), .valid(valid1), .rdata(rdata1), .err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected valid: got rdata 0x%08h err %0b, expected no response",
                             rdata, err);
                end else begin
                    mon_x = sb.pop_front();
                    checkOutput({mon_x.name, " err"}, 32'(err), 32'(mon_x.e));
                    checkOutput({mon_x.name, " rdata"}, rdata, mon_x.d);
                    checkOutput({mon_x.name, " latency"}, 32'(cyc), 32'(mon_x.at));
                end
            end else begin
                checkOutput("idle rdata", rdata, 32'h0);
                checkOutput("idle err", 32'(err), 32'h0);
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input bit release_rst);
        @(posedge clk);
        #1;
        if (release_rst) rst = 1'b1;
        we    = v.we;
        width = v.width;
        ext   = v.ext;
        addr  = v.addr;
        wdata = v.wdata;
        req   = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        sb.push_back('{v.exp_err, v.exp_rdata, cyc + LAT - 1, v.name});
        checkOutput({v.name, " busy ready"}, 32'(ready), 32'h0);
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got no response, expected one within 12 cycles", v.name);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t r;

        vecs.push_back('{1'b1, 2'b10, 1'b0, BASE,          32'h12345678, 1'b0, 32'h00000000, "st word 0"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE,          32'h0,        1'b0, 32'h12345678, "ld word 0"});
        vecs.push_back('{1'b1, 2'b00, 1'b0, BASE + 1,      32'h555555AB, 1'b0, 32'h00000000, "st byte 1"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, BASE + 1,      32'h0,        1'b0, 32'hFFFFFFAB, "ld byte 1 sx"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, BASE + 1,      32'h0,        1'b0, 32'h000000AB, "ld byte 1 zx"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE,          32'h0,        1'b0, 32'h1234AB78, "ld word 0 b"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, BASE + 4,      32'hCAFE1234, 1'b0, 32'h00000000, "st word 4"});
        vecs.push_back('{1'b1, 2'b01, 1'b0, BASE + 6,      32'h77778001, 1'b0, 32'h00000000, "st half 6"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, BASE + 6,      32'h0,        1'b0, 32'hFFFF8001, "ld half 6 sx"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE + 4,      32'h0,        1'b0, 32'h80011234, "ld word 4"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, BASE + 4,      32'h0,        1'b0, 32'h00001234, "ld half 4 zx"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, BASE + 7,      32'h0,        1'b0, 32'hFFFFFF80, "ld byte 7 sx"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, BASE + 3,      32'h0,        1'b0, 32'h00000012, "ld byte 3 zx"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE + 2,      32'h0,        1'b1, 32'h00000000, "ld word misal"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, BASE + 3,      32'h0,        1'b1, 32'h00000000, "ld half misal"});
        vecs.push_back('{1'b0, 2'b11, 1'b0, BASE,          32'h0,        1'b1, 32'h00000000, "ld width 11"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h1000FFFC,  32'h0,        1'b1, 32'h00000000, "ld below base"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10011000,  32'h0,        1'b1, 32'h00000000, "ld past depth"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, BASE + 2,      32'hFFFFFFFF, 1'b1, 32'h00000000, "st word misal"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10011000,  32'hFFFFFFFF, 1'b1, 32'h00000000, "st past depth"});
        vecs.push_back('{1'b1, 2'b01, 1'b0, BASE + 1,      32'hFFFFFFFF, 1'b1, 32'h00000000, "st half misal"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE,          32'h0,        1'b0, 32'h1234AB78, "ld word 0 kept"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE + 4,      32'h0,        1'b0, 32'h80011234, "ld word 4 kept"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h10010FFC,  32'hA5A55A5A, 1'b0, 32'h00000000, "st last word"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h10010FFC,  32'h0,        1'b0, 32'hA5A55A5A, "ld last word"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, BASE,          32'h0,        1'b0, 32'h1234AB78, "ld word 0 final"});

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset ready", 32'(ready), 32'h1);
        checkOutput("reset valid", 32'(valid), 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i == 0);
        end

        // Abort a store while it is waiting; the write must still be in memory.
        @(posedge clk);
        #1;
        we = 1'b1; width = 2'b10; ext = 1'b0; addr = BASE + 8; wdata = 32'hDEADBEEF; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("abort ready", 32'(ready), 32'h1);
        checkOutput("abort valid", 32'(valid), 32'h0);
        checkOutput("abort rdata", rdata, 32'h0);
        checkOutput("abort err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post-abort valid", 32'(valid), 32'h0);
            checkOutput("post-abort ready", 32'(ready), 32'h1);
        end
        r = '{1'b0, 2'b10, 1'b0, BASE + 8, 32'h0, 1'b0, 32'hDEADBEEF, "ld after abort"};
        applyStimulus(r, 1'b0);

        // LATENCY=3 with req held high: one acceptance every four cycles.
        @(posedge clk);
        #1;
        we = 1'b1; width = 2'b10; addr = BASE; wdata = 32'h11111111; req3 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput($sformatf("l3 ready c%0d", i), 32'(ready3), 32'((i % 4) == 0));
            checkOutput($sformatf("l3 valid c%0d", i), 32'(valid3), 32'((i % 4) == 3));
            checkOutput($sformatf("l3 err c%0d", i), 32'(err3), 32'h0);
        end
        req3 = 1'b0;

        // LATENCY=1: response on the cycle right after acceptance.
        @(posedge clk);
        #1;
        we = 1'b1; width = 2'b10; addr = BASE + 12; wdata = 32'h0BADF00D; req1 = 1'b1;
        @(negedge clk);
        checkOutput("l1 pre valid", 32'(valid1), 32'h0);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);
        checkOutput("l1 st valid", 32'(valid1), 32'h1);
        checkOutput("l1 st err", 32'(err1), 32'h0);
        checkOutput("l1 st rdata", rdata1, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0; req1 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);
        checkOutput("l1 ld valid", 32'(valid1), 32'h1);
        checkOutput("l1 ld rdata", rdata1, 32'h0BADF00D);
        @(negedge clk);
        checkOutput("l1 ld done valid", 32'(valid1), 32'h0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter BASE, default 32'h10010000: byte address of the first memory word.
REQ-002 SHALL have parameter DEPTH, default 1024: number of 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles from acceptance to response.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  initiator request strobe.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 addr  input  32  byte address.
REQ-009 width  input  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
REQ-010 ext  input  1  load extension: 0 sign-extend, 1 zero-extend (funct3[2]).
REQ-011 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 ready  output  1  responder can accept a request this cycle.
REQ-013 valid  output  1  one-cycle response pulse.
REQ-014 rdata  output  32  load result, right-aligned and extended.
REQ-015 err  output  1  response is an error; qualified by valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a cycle with req & ready; inputs are sampled only on that cycle.
REQ-018 On acceptance, SHALL go to RESP if LATENCY = 1; otherwise SHALL go to WAIT and load a down-counter with LATENCY-2.
REQ-019 In WAIT, SHALL decrement the counter each cycle and enter RESP on the cycle after it reaches 0.
REQ-020 SHALL assert valid exactly LATENCY cycles after the acceptance edge, for exactly one cycle, then return to IDLE; back-to-back acceptance period is therefore LATENCY+1 cycles.
REQ-021 SHALL compute the word index as (addr - BASE) >> 2 using a 32-bit unsigned subtract.
REQ-022 Error conditions: width = 11; width = 01 with addr[0] = 1; width = 10 with addr[1:0] != 0; addr < BASE; word index >= DEPTH.
REQ-023 On an error request, SHALL leave memory unchanged and respond with err = 1 and rdata = 0.
REQ-024 A legal store SHALL commit on the acceptance edge, writing only the addressed byte lanes: byte lane addr[1:0], half lanes {addr[1],0} and {addr[1],1}, or all four lanes.
REQ-025 Store responses SHALL have valid = 1, err = 0 and rdata = 0.
REQ-026 A legal load SHALL read the word on the acceptance edge and select the byte/half by addr[1:0].
REQ-027 The loaded byte/half SHALL be extended to 32 bits per ext.
REQ-028 rdata and err SHALL be 0 whenever valid = 0.
REQ-029 req while ready = 0 SHALL be ignored, with no queuing.
REQ-030 A load accepted after a store's response SHALL observe that store's data.
REQ-031 Memory contents SHALL NOT be initialised or reset by rst.

Reset
REQ-032 While rst = 0: state = IDLE, counter = 0, valid = 0, rdata = 0, err = 0, ready = 1.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately, with no response issued.
REQ-034 A store accepted before that reset SHALL remain committed.
REQ-035 The first acceptance SHALL be possible on the first rising edge with rst = 1.

Verification
REQ-036 LATENCY=2: store word 0x12345678 at 0x10010000 -> valid on cycle +2, err = 0; load word at 0x10010000 -> rdata = 0x12345678.
REQ-037 After REQ-036: store byte 0xAB at 0x10010001; load byte at 0x10010001 with ext = 0 -> 0xFFFFFFAB; same with ext = 1 -> 0x000000AB; load word -> 0x1234AB78.
REQ-038 Store half 0x8001 at 0x10010006; load half with ext = 0 -> 0xFFFF8001; load word at 0x10010004 -> bits [15:0] unchanged.
REQ-039 Load word at 0x10010002, half at 0x10010003, width = 11, addr 0x1000FFFC, and addr 0x10011000 (DEPTH = 1024) -> each gives err = 1, rdata = 0, memory unchanged.
REQ-040 Hold req = 1 continuously with LATENCY = 3 -> acceptances every 4 cycles and ready = 0 between them; with LATENCY = 1 -> valid on the cycle after acceptance.
REQ-041 Store 0xDEADBEEF, then assert rst = 0 in the WAIT state -> no valid pulse, outputs zero, ready = 1 after release; a subsequent load returns 0xDEADBEEF.
